// File: rtl/tsc_multi_capture_if.sv
// Purpose: sample-in / frame-out streaming bundle of the TSC capture controller.
// Ports (signals):
//   adc_valid  one sample set present on adc_data
//   adc_data   CH*DW packed samples, channel k at [k*DW +: DW]
//   out_ready  downstream accepts out_data
//   out_valid  out_data holds a frame sample
//   out_data   frame sample, same packing as adc_data
//   out_last   high with the final frame sample
// Modports: master = capture controller, slave = ADC source / frame sink.
interface tsc_multi_capture_if #(
    parameter int unsigned CH = 2,
    parameter int unsigned DW = 8
) ();
    logic               adc_valid;
    logic [CH*DW-1:0]   adc_data;
    logic               out_ready;
    logic               out_valid;
    logic [CH*DW-1:0]   out_data;
    logic               out_last;

    modport master (
        input  adc_valid,
        input  adc_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output adc_valid,
        output adc_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/tsc_multi_capture.sv
// Purpose: multi-channel trigger/sample capture controller. Samples go into a
// circular buffer; a threshold crossing on the selected channel triggers a
// frame of PRE pre-trigger and DEPTH-PRE post-trigger samples, which is then
// streamed oldest-first and held until the hub acknowledges with sbf.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, abort      arm request (IDLE only) / cancel from any state
//   sbf               hub acknowledge, honoured only in WAIT_SBF
//   cfg_trig_ch       trigger channel (out-of-range selects channel 0)
//   cfg_threshold     unsigned trigger threshold
//   cfg_edge          0 = rising crossing, 1 = falling crossing
//   bus               sample input and frame output streams
//   trd               one-cycle pulse on frame complete
//   trig_time         timestamp of the trigger sample
//   state_out, busy   FSM state and not-idle flag
module tsc_multi_capture #(
    parameter int unsigned CH    = 2,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned PRE   = 8,
    parameter int unsigned TSW   = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic                                   sbf,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_trig_ch,
    input  logic [DW-1:0]                          cfg_threshold,
    input  logic                                   cfg_edge,
    tsc_multi_capture_if.master                    bus,
    output logic                                   trd,
    output logic [TSW-1:0]                         trig_time,
    output logic [2:0]                             state_out,
    output logic                                   busy
);
    localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned SW   = CH * DW;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POST     = 3'd3,
        ST_READ     = 3'd4,
        ST_WAIT_SBF = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [CNTW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]     trig_ch_q, trig_ch_d;
    logic [DW-1:0]     thr_q, thr_d;
    logic              edge_q, edge_d;
    logic [DW-1:0]     prev_q, prev_d;
    logic [TSW-1:0]    ts_q, ts_d;
    logic [TSW-1:0]    trig_time_q, trig_time_d;
    logic              out_valid_q, out_valid_d;
    logic [SW-1:0]     out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              trd_q, trd_d;
    logic              busy_q, busy_d;

    logic [SW-1:0]     mem_q [DEPTH];

    logic              wr_en_c;
    logic [DW-1:0]     cur_smp_c;
    logic              trig_hit_c;

    // Selected trigger channel of the incoming sample set.
    always_comb begin
        cur_smp_c = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (trig_ch_q == CW'(k)) begin
                cur_smp_c = bus.adc_data[k*DW +: DW];
            end
        end
    end

    // Samples are stored only while capturing; abort suppresses the write.
    always_comb begin
        wr_en_c = bus.adc_valid && !abort &&
                  ((state_q == ST_FILL) || (state_q == ST_ARMED) || (state_q == ST_POST));
    end

    // prev_q is the last written sample of the trigger channel.
    always_comb begin
        if (edge_q) begin
            trig_hit_c = (prev_q >= thr_q) && (cur_smp_c < thr_q);
        end else begin
            trig_hit_c = (prev_q < thr_q) && (cur_smp_c >= thr_q);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        ld_cnt_d    = ld_cnt_q;
        trig_ch_d   = trig_ch_q;
        thr_d       = thr_q;
        edge_d      = edge_q;
        prev_d      = prev_q;
        ts_d        = ts_q + TSW'(1);
        trig_time_d = trig_time_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        trd_d       = 1'b0;

        if (wr_en_c) begin
            wp_d   = wp_q + AW'(1);
            prev_d = cur_smp_c;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FILL;
                    trig_ch_d = (32'(cfg_trig_ch) < CH) ? cfg_trig_ch : '0;
                    thr_d     = cfg_threshold;
                    edge_d    = cfg_edge;
                    wp_d      = '0;
                    cnt_d     = '0;
                end
            end
            ST_FILL: begin
                if (wr_en_c) begin
                    if (cnt_q == CNTW'(PRE - 1)) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            ST_ARMED: begin
                // Trigger sample counts as post sample #1; frame starts PRE before it.
                if (wr_en_c && trig_hit_c) begin
                    trig_time_d = ts_q;
                    rd_ptr_d    = wp_q - AW'(PRE);
                    cnt_d       = CNTW'(1);
                    ld_cnt_d    = '0;
                    if (DEPTH - PRE == 1) begin
                        state_d = ST_READ;
                        trd_d   = 1'b1;
                    end else begin
                        state_d = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (wr_en_c) begin
                    if (cnt_q == CNTW'(DEPTH - PRE - 1)) begin
                        state_d = ST_READ;
                        trd_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            ST_READ: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_WAIT_SBF;
                    end
                end
                // Refill the output register when empty or being drained.
                if ((ld_cnt_q != CNTW'(DEPTH)) && (!out_valid_q || bus.out_ready)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_q[rd_ptr_q];
                    out_last_d  = (ld_cnt_q == CNTW'(DEPTH - 1));
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                    ld_cnt_d    = ld_cnt_q + CNTW'(1);
                end
            end
            ST_WAIT_SBF: begin
                if (sbf) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            trd_d       = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Sample buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wp_q] <= bus.adc_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wp_q        <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ld_cnt_q    <= '0;
            trig_ch_q   <= '0;
            thr_q       <= '0;
            edge_q      <= 1'b0;
            prev_q      <= '0;
            ts_q        <= '0;
            trig_time_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            trd_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ld_cnt_q    <= ld_cnt_d;
            trig_ch_q   <= trig_ch_d;
            thr_q       <= thr_d;
            edge_q      <= edge_d;
            prev_q      <= prev_d;
            ts_q        <= ts_d;
            trig_time_q <= trig_time_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            trd_q       <= trd_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign trd           = trd_q;
    assign trig_time     = trig_time_q;
    assign state_out     = state_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_tsc_multi_capture.sv
// Purpose: directed bench for tsc_multi_capture (CH=2, DW=8, DEPTH=32, PRE=8).
module tb_tsc_multi_capture;
    localparam int unsigned CH    = 2;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned PRE   = 8;
    localparam int unsigned TSW   = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        sbf = 1'b0;
    logic [0:0]  cfg_trig_ch = 1'b0;
    logic [7:0]  cfg_threshold = 8'd0;
    logic        cfg_edge = 1'b0;
    logic        trd;
    logic [31:0] trig_time;
    logic [2:0]  state_out;
    logic        busy;

    tsc_multi_capture_if #(.CH(CH), .DW(DW)) bus ();

    tsc_multi_capture #(
        .CH(CH), .DW(DW), .DEPTH(DEPTH), .PRE(PRE), .TSW(TSW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .sbf           (sbf),
        .cfg_trig_ch   (cfg_trig_ch),
        .cfg_threshold (cfg_threshold),
        .cfg_edge      (cfg_edge),
        .bus           (bus),
        .trd           (trd),
        .trig_time     (trig_time),
        .state_out     (state_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] tb_ts = 32'd0;
    int          trd_cnt = 0;
    int          ovl_cnt = 0;
    logic [31:0] exp_tt;

    // Reference timestamp, trd pulse count and trd/out_valid overlap count.
    always @(posedge clk) begin
        tb_ts <= reset ? 32'd0 : tb_ts + 32'd1;
        if (trd) trd_cnt <= trd_cnt + 1;
        if (trd && bus.out_valid) ovl_cnt <= ovl_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stimulus sample i of test t, packed {ch1, ch0}.
    function automatic logic [15:0] smp(input int t, input int i);
        logic [7:0] c0;
        logic [7:0] c1;
        case (t)
            1: begin
                c0 = 8'(i);
                c1 = 8'(200 - i);
            end
            2: begin
                c1 = (i < 40) ? 8'd50 : 8'd10;
                c0 = (i < 20) ? 8'd100 : 8'(i);
            end
            default: begin
                c1 = 8'(i);
                if (i < 8)        c0 = (i % 2 == 1) ? 8'd150 : 8'd50;
                else if (i < 108) c0 = 8'(i % 64);
                else              c0 = 8'd200;
            end
        endcase
        return {c1, c0};
    endfunction

    task automatic send(input logic [15:0] d);
        bus.adc_valid = 1'b1;
        bus.adc_data  = d;
        @(posedge clk); #1;
        bus.adc_valid = 1'b0;
    endtask

    task automatic arm(input logic ch, input logic [7:0] thr, input logic edg);
        cfg_trig_ch   = ch;
        cfg_threshold = thr;
        cfg_edge      = edg;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_sbf();
        sbf = 1'b1;
        @(posedge clk); #1;
        sbf = 1'b0;
    endtask

    // Drain one frame (called in the trd cycle); frame beat j is sample base+j of test t.
    task automatic read_frame(input bit rnd, input bit sbf_mid, input int base, input int t,
                              input string nm);
        logic [15:0] rx_d [DEPTH];
        logic        rx_l [DEPTH];
        int          n = 0;
        int          first = -1;
        int          serr = 0;
        bit          stalled = 1'b0;
        bit          done = 1'b0;
        logic [15:0] hd = '0;
        logic        hl = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sbf = sbf_mid && (cyc == 6);
            @(negedge clk);
            if (stalled && (!bus.out_valid || bus.out_data !== hd || bus.out_last !== hl)) serr++;
            stalled = 1'b0;
            if (bus.out_valid) begin
                if (first < 0) first = cyc;
                if (bus.out_ready) begin
                    if (n < int'(DEPTH)) begin
                        rx_d[n] = bus.out_data;
                        rx_l[n] = bus.out_last;
                    end
                    n++;
                    if (bus.out_last) done = 1'b1;
                end else begin
                    stalled = 1'b1;
                    hd = bus.out_data;
                    hl = bus.out_last;
                end
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        sbf = 1'b0;
        check({nm, "_beats"}, 64'(n), 64'(DEPTH));
        check({nm, "_first_valid_lat"}, 64'(first >= 1 && first <= 2), 64'd1);
        check({nm, "_stall_hold"}, 64'(serr), 64'd0);
        for (int j = 0; j < n && j < int'(DEPTH); j++) begin
            check($sformatf("%s_data%0d", nm, j), 64'(rx_d[j]), 64'(smp(t, base + j)));
            check($sformatf("%s_last%0d", nm, j), 64'(rx_l[j]), 64'(j == int'(DEPTH) - 1));
        end
    endtask

    initial begin
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_state", 64'(state_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_trd", 64'(trd), 64'd0);
        check("rst_trig_time", 64'(trig_time), 64'd0);

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 64'(state_out), 64'd0);

        // Rising ramp on ch0, threshold 20.
        arm(1'b0, 8'd20, 1'b0);
        check("t1_fill", 64'(state_out), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 44; i++) begin
            if (i == 20) exp_tt = tb_ts;
            send(smp(1, i));
            if (i == 7)  check("t1_armed", 64'(state_out), 64'd2);
            if (i == 19) check("t1_no_early_trig", 64'(state_out), 64'd2);
            if (i == 20) check("t1_post", 64'(state_out), 64'd3);
            if (i == 42) check("t1_no_trd_yet", 64'(trd), 64'd0);
            if (i == 43) begin
                check("t1_trd", 64'(trd), 64'd1);
                check("t1_read", 64'(state_out), 64'd4);
            end
        end
        check("t1_trig_time", 64'(trig_time), 64'(exp_tt));
        read_frame(1'b0, 1'b0, 12, 1, "t1");
        check("t1_wait_sbf", 64'(state_out), 64'd5);
        check("t1_valid_drop", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check("t1_hold_wait", 64'(state_out), 64'd5);
        pulse_sbf();
        check("t1_idle", 64'(state_out), 64'd0);
        check("t1_trd_once", 64'(trd_cnt), 64'd1);

        // Falling edge on ch1, threshold 30; ch0 falls through 30 at sample 20.
        arm(1'b1, 8'd30, 1'b1);
        for (int i = 0; i < 64; i++) begin
            if (i == 40) exp_tt = tb_ts;
            send(smp(2, i));
            if (i == 39) check("t2_ch0_ignored", 64'(state_out), 64'd2);
            if (i == 63) check("t2_trd", 64'(trd), 64'd1);
        end
        check("t2_trig_time", 64'(trig_time), 64'(exp_tt));
        read_frame(1'b0, 1'b0, 32, 2, "t2");
        pulse_sbf();
        check("t2_idle", 64'(state_out), 64'd0);

        // Crossings during FILL ignored; 100 ARMED samples wrap the buffer; random ready.
        arm(1'b0, 8'd100, 1'b0);
        for (int i = 0; i < 132; i++) begin
            if (i == 108) exp_tt = tb_ts;
            send(smp(3, i));
            if (i == 7)   check("t3_fill_no_trig", 64'(state_out), 64'd2);
            if (i == 107) check("t3_armed_long", 64'(state_out), 64'd2);
            if (i == 131) check("t3_trd", 64'(trd), 64'd1);
        end
        check("t3_trig_time", 64'(trig_time), 64'(exp_tt));
        read_frame(1'b1, 1'b1, 100, 3, "t3");
        check("t3_early_sbf_ignored", 64'(state_out), 64'd5);
        pulse_sbf();
        check("t3_idle", 64'(state_out), 64'd0);
        check("t3_trd_count", 64'(trd_cnt), 64'd3);

        // Abort in POST: trig_time kept, no trd.
        arm(1'b0, 8'd20, 1'b0);
        for (int i = 0; i < 25; i++) begin
            if (i == 20) exp_tt = tb_ts;
            send(smp(1, i));
        end
        check("ab_post_state", 64'(state_out), 64'd3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_post_idle", 64'(state_out), 64'd0);
        check("ab_post_busy", 64'(busy), 64'd0);
        check("ab_post_tt_kept", 64'(trig_time), 64'(exp_tt));
        for (int i = 25; i < 55; i++) send(smp(1, i));
        check("ab_post_no_trd", 64'(trd_cnt), 64'd3);
        check("ab_post_stay_idle", 64'(state_out), 64'd0);

        // Abort while READ is stalled.
        arm(1'b0, 8'd20, 1'b0);
        for (int i = 0; i < 44; i++) send(smp(1, i));
        check("ab_rd_trd", 64'(trd), 64'd1);
        for (int k = 0; k < 4 && !bus.out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("ab_rd_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        check("ab_rd_stall_data", 64'(bus.out_data), 64'(smp(1, 12)));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_rd_idle", 64'(state_out), 64'd0);
        check("ab_rd_valid_low", 64'(bus.out_valid), 64'd0);
        check("ab_rd_last_low", 64'(bus.out_last), 64'd0);

        // Reset while ARMED.
        arm(1'b0, 8'd20, 1'b0);
        for (int i = 0; i < 15; i++) send(smp(1, i));
        check("rs_armed", 64'(state_out), 64'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rs_idle", 64'(state_out), 64'd0);
        check("rs_valid", 64'(bus.out_valid), 64'd0);
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_trig_time", 64'(trig_time), 64'd0);
        for (int i = 15; i < 50; i++) send(smp(1, i));
        check("rs_no_trd", 64'(trd_cnt), 64'd4);
        check("rs_stay_idle", 64'(state_out), 64'd0);
        check("trd_valid_overlap", 64'(ovl_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
